clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Button-driven time-setting controller for the real-time clock.
- Sits between the board push-buttons and the clock's load/addrs/data_in configuration port.
- Captures the running time into shadow registers and lets the user edit hours, minutes and seconds.
- On commit, writes the fields into the seconds/minutes/hours counters as a sequenced burst of single-cycle load pulses. Also drives edit status and a blink strobe for the display.

Parameters:
- REPEAT_DLY, 50_000_000: cycles btn_inc must be held before auto-repeat starts.
- REPEAT_PER, 10_000_000: cycles between auto-repeat increments.
- TIMEOUT_CYC, 1_000_000_000: idle cycles in an edit state before abort.
- BLINK_CYC, 25_000_000: half-period of blink, in cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- btn_set  in  1  debounced, synchronous level; enter edit / abort
- btn_next  in  1  debounced level; advance field / commit
- btn_inc  in  1  debounced level; increment selected field
- cur_seconds  in  6  live seconds from clock
- cur_minutes  in  6  live minutes
- cur_hours  in  5  live hours
- load  out  1  one-cycle write strobe to clock
- addrs  out  2  target field: 00 seconds, 01 minutes, 10 hours (11 never driven)
- data_in  out  6  write value, zero-extended for hours
- edit_active  out  1  high in any EDIT state
- edit_field  out  2  field being edited, same encoding as addrs; 00 when not editing
- blink  out  1  blink strobe for the edited digits

Behaviour:
- Reset is synchronous, active-low: at a clk edge with reset==0, the block enters IDLE.
  - All outputs go to 0.
  - Shadow registers, repeat counter, timeout counter and blink counter clear.
  - Edge-detect registers clear.
- Button inputs are rising-edge detected internally; a press means 0->1 on consecutive clocks.
- Same-cycle press priority: set > next > inc. Lower-priority presses in that cycle are ignored.
- State machine: IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, WR_SEC, WR_MIN, WR_HR.
- IDLE:
  - On set press, copy cur_* into shadow sh_s, sh_m, sh_h, then go to EDIT_HR.
  - next and inc presses are ignored.
- EDIT_x, where edit_field is 10 for HR, 01 for MIN, 00 for SEC:
  - set press: abort to IDLE; no load is issued.
  - next press: HR->MIN->SEC->WR_SEC.
  - inc press: shadow field +1 with wrap, 23->0 for hours and 59->0 for minutes/seconds.
  - Holding btn_inc for REPEAT_DLY cycles after the press gives one extra increment, then one every REPEAT_PER cycles until release. The repeat counter clears on release or on a state change.
  - Timeout counter clears on any button press or state entry. Reaching TIMEOUT_CYC-1 aborts to IDLE with no write.
- Write burst, exactly 3 consecutive cycles, one per state:
  - WR_SEC: load=1, addrs=00, data_in=sh_s.
  - WR_MIN: load=1, addrs=01, data_in=sh_m.
  - WR_HR: load=1, addrs=10, data_in={1'b0,sh_h}.
  - Then IDLE.
  - Buttons are ignored during the burst.
  - Latency: load first asserts on the cycle after the commit press is registered.
- Outputs are registered. load is 0 outside the WR states; addrs/data_in hold their last value when load=0.
- edit_active is 1 only in EDIT_HR, EDIT_MIN and EDIT_SEC.
- blink:
  - Toggles every BLINK_CYC cycles while edit_active.
  - Forced to 1 on entry to each EDIT state and on each increment, so the value is visible while changing.
  - 0 when not editing.
- Shadow values are never out of range: the wrap comparison is on equality with the max value.
- Reset mid-burst: the burst stops at once; remaining loads are not issued.

Decomposition:
- Shared package clk_pkg holds:
  - Field/address constants: ADDR_SEC=2'b00, ADDR_MIN=2'b01, ADDR_HR=2'b10.
  - Limits: SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
  - State encoding constants.
- One sub-module, btn_edge: rising-edge detector with hold counter, parameterized by REPEAT_DLY/REPEAT_PER. It outputs an inc_pulse covering both the press and the auto-repeat pulses; this block instantiates it for btn_inc. The set/next edge detectors are inline.

Test Plan:
- Small parameters (REPEAT_DLY=8, REPEAT_PER=4, TIMEOUT_CYC=64, BLINK_CYC=3).
- Reset low 2 cycles -> all outputs 0, state IDLE; inc/next presses in IDLE -> load never asserts.
- cur=12:34:56; set, inc x3 (hours), next, inc x1, next, next -> exactly 3 consecutive load cycles with (00,56), (01,35), (10,15); edit_active=0 afterward.
- Wrap: shadow hours 23 + inc -> 0; minutes 59 + inc -> 0; commit -> data_in for addrs=10 is 0.
- Hold btn_inc 20 cycles in EDIT_MIN starting from 10 -> 1 press + repeats at cycles 8, 12, 16, 20 -> shadow 15.
- Abort: set in EDIT_SEC, or no press for 64 cycles -> IDLE with zero load pulses; set+next pressed in same cycle in EDIT_HR -> abort.
- Reset asserted during WR_MIN -> no WR_HR load; outputs 0 next cycle.

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the time-setting
// controller: field addresses, field limits and wrap-around increments.
package clk_pkg;

  // Field / address encoding shared by addrs and edit_field
  localparam logic [1:0] ADDR_SEC = 2'b00;
  localparam logic [1:0] ADDR_MIN = 2'b01;
  localparam logic [1:0] ADDR_HR  = 2'b10;

  // Largest legal value of each time field
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  // Controller state encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EDIT_HR  = 3'd1,
    ST_EDIT_MIN = 3'd2,
    ST_EDIT_SEC = 3'd3,
    ST_WR_SEC   = 3'd4,
    ST_WR_MIN   = 3'd5,
    ST_WR_HR    = 3'd6
  } state_t;

  // Increment a 6-bit field, wrapping to zero after its maximum
  function automatic logic [5:0] wrap_inc6(input logic [5:0] value,
                                           input logic [5:0] max_value);
    return (value == max_value) ? 6'd0 : value + 6'd1;
  endfunction

  // Increment the 5-bit hours field, wrapping to zero after its maximum
  function automatic logic [4:0] wrap_inc5(input logic [4:0] value,
                                           input logic [4:0] max_value);
    return (value == max_value) ? 5'd0 : value + 5'd1;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button / live-time / clock-configuration bundle for the time-setting
// controller. master = controller side, slave = board/clock side.
interface clock_set_ctrl_if;
  logic       btn_set;
  logic       btn_next;
  logic       btn_inc;
  logic [5:0] cur_seconds;
  logic [5:0] cur_minutes;
  logic [4:0] cur_hours;
  logic       load;
  logic [1:0] addrs;
  logic [5:0] data_in;
  logic       edit_active;
  logic [1:0] edit_field;
  logic       blink;

  modport master (
    input  btn_set, btn_next, btn_inc,
    input  cur_seconds, cur_minutes, cur_hours,
    output load, addrs, data_in,
    output edit_active, edit_field, blink
  );

  modport slave (
    output btn_set, btn_next, btn_inc,
    output cur_seconds, cur_minutes, cur_hours,
    input  load, addrs, data_in,
    input  edit_active, edit_field, blink
  );
endinterface

// File: rtl/clock_set_ctrl_btn_edge.sv
// Rising-edge detector with hold-to-repeat. pulse fires for one cycle on
// the press, then after REPEAT_DLY held cycles, then every REPEAT_PER held
// cycles until release. clr discards any hold progress (field change).
module btn_edge #(
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clr,
  output logic pulse
);

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  logic             prev_reg;
  logic             rpt_reg;   // first repeat already issued -> use REPEAT_PER
  logic [CNT_W-1:0] cnt_reg;   // cycles held since press or last repeat; 0 = idle
  logic             press;
  logic             rpt_hit;
  logic [CNT_W-1:0] target;

  assign press   = btn & ~prev_reg;
  assign target  = rpt_reg ? CNT_W'(REPEAT_PER) : CNT_W'(REPEAT_DLY);
  assign rpt_hit = btn & prev_reg & ~clr & (cnt_reg != '0) & (cnt_reg == target);
  assign pulse   = press | rpt_hit;

  // Track the previous level and the hold counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_reg <= 1'b0;
      rpt_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      prev_reg <= btn;
      if (!btn) begin
        cnt_reg <= '0;
        rpt_reg <= 1'b0;
      end else if (press) begin
        cnt_reg <= CNT_W'(1);
        rpt_reg <= 1'b0;
      end else if (clr) begin
        cnt_reg <= '0;
        rpt_reg <= 1'b0;
      end else if (rpt_hit) begin
        cnt_reg <= CNT_W'(1);
        rpt_reg <= 1'b1;
      end else if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time-setting controller. Captures the live time into shadow
// registers, lets the user edit hours/minutes/seconds, and commits them to
// the clock as a three-cycle burst of load strobes (sec, min, hr).
module clock_set_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned REPEAT_DLY  = 50_000_000,
  parameter int unsigned REPEAT_PER  = 10_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000,
  parameter int unsigned BLINK_CYC   = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  clock_set_ctrl_if.master  bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BL_W = $clog2(BLINK_CYC + 1);

  state_t          state_reg;
  logic [5:0]      sh_s_reg;
  logic [5:0]      sh_m_reg;
  logic [4:0]      sh_h_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic [BL_W-1:0] blink_cnt_reg;
  logic            set_prev_reg;
  logic            next_prev_reg;
  logic            inc_clr_reg;

  logic            load_reg;
  logic [1:0]      addrs_reg;
  logic [5:0]      data_reg;
  logic            edit_active_reg;
  logic [1:0]      edit_field_reg;
  logic            blink_reg;

  logic            set_press;
  logic            next_press;
  logic            inc_pulse;
  logic            set_evt;
  logic            next_evt;
  logic            inc_evt;
  logic            any_evt;
  logic            is_edit;

  assign set_press  = bus.btn_set  & ~set_prev_reg;
  assign next_press = bus.btn_next & ~next_prev_reg;

  // Same-cycle priority: set over next over inc
  assign set_evt  = set_press;
  assign next_evt = next_press & ~set_press;
  assign inc_evt  = inc_pulse & ~set_press & ~next_press;
  assign any_evt  = set_press | next_press | inc_pulse;

  assign is_edit = (state_reg == ST_EDIT_HR) || (state_reg == ST_EDIT_MIN) ||
                   (state_reg == ST_EDIT_SEC);

  // Increment button with auto-repeat; hold progress is dropped on field change
  btn_edge #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_inc_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_inc),
    .clr   (inc_clr_reg),
    .pulse (inc_pulse)
  );

  // Previous-level registers for the set/next edge detectors
  always_ff @(posedge clk) begin
    if (!reset) begin
      set_prev_reg  <= 1'b0;
      next_prev_reg <= 1'b0;
    end else begin
      set_prev_reg  <= bus.btn_set;
      next_prev_reg <= bus.btn_next;
    end
  end

  // Main FSM with shadow registers, timeout, blink and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      sh_s_reg        <= '0;
      sh_m_reg        <= '0;
      sh_h_reg        <= '0;
      to_cnt_reg      <= '0;
      blink_cnt_reg   <= '0;
      inc_clr_reg     <= 1'b0;
      load_reg        <= 1'b0;
      addrs_reg       <= '0;
      data_reg        <= '0;
      edit_active_reg <= 1'b0;
      edit_field_reg  <= '0;
      blink_reg       <= 1'b0;
    end else begin
      load_reg    <= 1'b0;
      inc_clr_reg <= 1'b0;

      // Free-running blink and idle timeout while editing; transitions below override
      if (is_edit) begin
        if (blink_cnt_reg == BL_W'(BLINK_CYC - 1)) begin
          blink_reg     <= ~blink_reg;
          blink_cnt_reg <= '0;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + BL_W'(1);
        end
        if (any_evt) to_cnt_reg <= '0;
        else         to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          if (set_evt) begin
            sh_s_reg        <= bus.cur_seconds;
            sh_m_reg        <= bus.cur_minutes;
            sh_h_reg        <= bus.cur_hours;
            state_reg       <= ST_EDIT_HR;
            edit_active_reg <= 1'b1;
            edit_field_reg  <= ADDR_HR;
            blink_reg       <= 1'b1;
            blink_cnt_reg   <= '0;
            to_cnt_reg      <= '0;
            inc_clr_reg     <= 1'b1;
          end
        end

        ST_EDIT_HR, ST_EDIT_MIN, ST_EDIT_SEC: begin
          if (set_evt || (!any_evt && to_cnt_reg == TO_W'(TIMEOUT_CYC - 1))) begin
            // Abort (user or timeout): drop edits, no write
            state_reg       <= ST_IDLE;
            edit_active_reg <= 1'b0;
            edit_field_reg  <= ADDR_SEC;
            blink_reg       <= 1'b0;
            blink_cnt_reg   <= '0;
            to_cnt_reg      <= '0;
            inc_clr_reg     <= 1'b1;
          end else if (next_evt) begin
            blink_cnt_reg <= '0;
            to_cnt_reg    <= '0;
            inc_clr_reg   <= 1'b1;
            if (state_reg == ST_EDIT_HR) begin
              state_reg      <= ST_EDIT_MIN;
              edit_field_reg <= ADDR_MIN;
              blink_reg      <= 1'b1;
            end else if (state_reg == ST_EDIT_MIN) begin
              state_reg      <= ST_EDIT_SEC;
              edit_field_reg <= ADDR_SEC;
              blink_reg      <= 1'b1;
            end else begin
              // Commit: first strobe goes out with the state change
              state_reg       <= ST_WR_SEC;
              edit_active_reg <= 1'b0;
              edit_field_reg  <= ADDR_SEC;
              blink_reg       <= 1'b0;
              load_reg        <= 1'b1;
              addrs_reg       <= ADDR_SEC;
              data_reg        <= sh_s_reg;
            end
          end else if (inc_evt) begin
            blink_reg     <= 1'b1;
            blink_cnt_reg <= '0;
            case (state_reg)
              ST_EDIT_HR:  sh_h_reg <= wrap_inc5(sh_h_reg, HR_MAX);
              ST_EDIT_MIN: sh_m_reg <= wrap_inc6(sh_m_reg, MIN_MAX);
              default:     sh_s_reg <= wrap_inc6(sh_s_reg, SEC_MAX);
            endcase
          end
        end

        ST_WR_SEC: begin
          state_reg <= ST_WR_MIN;
          load_reg  <= 1'b1;
          addrs_reg <= ADDR_MIN;
          data_reg  <= sh_m_reg;
        end

        ST_WR_MIN: begin
          state_reg <= ST_WR_HR;
          load_reg  <= 1'b1;
          addrs_reg <= ADDR_HR;
          data_reg  <= {1'b0, sh_h_reg};
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.load        = load_reg;
  assign bus.addrs       = addrs_reg;
  assign bus.data_in     = data_reg;
  assign bus.edit_active = edit_active_reg;
  assign bus.edit_field  = edit_field_reg;
  assign bus.blink       = blink_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: expected writes are queued when a
// commit is driven and checked as load strobes appear.
module tb_clock_set_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .REPEAT_DLY  (8),
    .REPEAT_PER  (4),
    .TIMEOUT_CYC (64),
    .BLINK_CYC   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] addr;
    logic [5:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  load_cnt = 0;
  int  base_cnt;
  logic [3:0] pat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every load strobe must match the next queued write
  always @(negedge clk) begin
    if (bus.load === 1'b1) begin
      load_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_load", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("write addrs=%0d data=%0d (exp %0d/%0d)", bus.addrs, bus.data_in,
                 mon_e.addr, mon_e.data);
        chk("wr_addrs", 32'(bus.addrs), 32'(mon_e.addr));
        chk("wr_data", 32'(bus.data_in), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0=set 1=next 2=inc 3=set+next; returns #1 after the registering edge
  task automatic press(input int which);
    @(posedge clk);
    #1;
    bus.btn_set  = (which == 0) || (which == 3);
    bus.btn_next = (which == 1) || (which == 3);
    bus.btn_inc  = (which == 2);
    @(posedge clk);
    #1;
    bus.btn_set  = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_inc  = 1'b0;
  endtask

  task automatic enter_edit(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    bus.cur_hours   = h;
    bus.cur_minutes = m;
    bus.cur_seconds = s;
    press(0);
    chk("enter_active", 32'(bus.edit_active), 32'd1);
    chk("enter_field", 32'(bus.edit_field), 32'd2);
    chk("enter_blink", 32'(bus.blink), 32'd1);
  endtask

  // Commit from EDIT_SEC and verify the 1,1,1,0 load pattern
  task automatic commit(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
    exp_q.push_back('{addr: 2'b00, data: s});
    exp_q.push_back('{addr: 2'b01, data: m});
    exp_q.push_back('{addr: 2'b10, data: {1'b0, h}});
    press(1);
    pat = {3'b000, bus.load};
    for (int i = 0; i < 3; i++) begin
      tick();
      pat = {pat[2:0], bus.load};
    end
    chk("burst_pattern", 32'(pat), 32'b1110);
    chk("post_active", 32'(bus.edit_active), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.btn_set = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_inc = 1'b0;
    bus.cur_seconds = 6'd0;
    bus.cur_minutes = 6'd0;
    bus.cur_hours = 5'd0;

    // Reset state
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_load", 32'(bus.load), 32'd0);
    chk("rst_addrs", 32'(bus.addrs), 32'd0);
    chk("rst_data", 32'(bus.data_in), 32'd0);
    chk("rst_active", 32'(bus.edit_active), 32'd0);
    chk("rst_field", 32'(bus.edit_field), 32'd0);
    chk("rst_blink", 32'(bus.blink), 32'd0);
    reset = 1'b1;

    // inc/next in IDLE do nothing
    press(2);
    press(1);
    repeat (4) tick();
    chk("idle_noload", 32'(load_cnt), 32'd0);
    chk("idle_active", 32'(bus.edit_active), 32'd0);

    // Basic edit 12:34:56 -> 15:35:56
    enter_edit(5'd12, 6'd34, 6'd56);
    repeat (3) press(2);
    press(1);
    chk("field_min", 32'(bus.edit_field), 32'd1);
    press(2);
    press(1);
    chk("field_sec", 32'(bus.edit_field), 32'd0);
    commit(6'd56, 6'd35, 5'd15);

    // Wrap 23:59:07 -> 00:00:07
    enter_edit(5'd23, 6'd59, 6'd7);
    press(2);
    press(1);
    press(2);
    press(1);
    commit(6'd7, 6'd0, 5'd0);

    // Auto-repeat: minutes 10 held -> 15
    enter_edit(5'd5, 6'd10, 6'd20);
    press(1);
    @(posedge clk);
    #1;
    bus.btn_inc = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    bus.btn_inc = 1'b0;
    press(1);
    commit(6'd20, 6'd15, 5'd5);

    // Abort with set in EDIT_SEC
    base_cnt = load_cnt;
    enter_edit(5'd1, 6'd1, 6'd1);
    press(1);
    press(1);
    press(0);
    chk("abort_set_active", 32'(bus.edit_active), 32'd0);
    repeat (5) tick();
    chk("abort_set_noload", 32'(load_cnt - base_cnt), 32'd0);

    // Timeout abort plus blink toggle
    base_cnt = load_cnt;
    enter_edit(5'd2, 6'd2, 6'd2);
    repeat (3) tick();
    chk("blink_toggle", 32'(bus.blink), 32'd0);
    repeat (57) tick();
    chk("timeout_still_edit", 32'(bus.edit_active), 32'd1);
    repeat (8) tick();
    chk("timeout_idle", 32'(bus.edit_active), 32'd0);
    chk("timeout_blink", 32'(bus.blink), 32'd0);
    chk("timeout_noload", 32'(load_cnt - base_cnt), 32'd0);

    // set+next together in EDIT_HR -> abort
    base_cnt = load_cnt;
    enter_edit(5'd3, 6'd3, 6'd3);
    press(3);
    chk("setnext_active", 32'(bus.edit_active), 32'd0);
    chk("setnext_field", 32'(bus.edit_field), 32'd0);
    repeat (5) tick();
    chk("setnext_noload", 32'(load_cnt - base_cnt), 32'd0);

    // Reset during WR_MIN: hours write must not appear
    base_cnt = load_cnt;
    enter_edit(5'd1, 6'd2, 6'd3);
    press(1);
    press(1);
    exp_q.push_back('{addr: 2'b00, data: 6'd3});
    exp_q.push_back('{addr: 2'b01, data: 6'd2});
    press(1);
    tick();
    reset = 1'b0;
    tick();
    chk("rstburst_load", 32'(bus.load), 32'd0);
    chk("rstburst_addrs", 32'(bus.addrs), 32'd0);
    chk("rstburst_data", 32'(bus.data_in), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("rstburst_count", 32'(load_cnt - base_cnt), 32'd2);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
